mic_frame_scheduler: RTL and testbench

Gathers the per-microphone I2S sample pulses (one `data_valid_out`/`audio_out` pair per `i2s` instance) into one aligned multi-channel frame. Downstream consumers (PDM monitor mux, delay/localisation datapath) see a single valid/ready stream instead of three free-running strobes. Sits between the `i2s` receivers and everything that consumes mic audio in `top_level`, on the 98.3 MHz audio clock.

---
 rtl/mic_sched_pkg.sv | 30 +++
 rtl/mic_frame_scheduler_if.sv | 37 +++
 rtl/mic_lane_slot.sv | 84 ++++++++
 rtl/mic_frame_scheduler.sv | 123 ++++++++++++
 tb/tb_mic_frame_scheduler.sv | 273 +++++++++++++++++++++++++++
 5 files changed

// File: rtl/mic_sched_pkg.sv
// rtl/mic_sched_pkg.sv - shared state type, default sizes and stats helper for mic_frame_scheduler
//
// Contents:
//   state_e            scheduler states (IDLE / COLLECT / EMIT)
//   DEF_NUM_MICS       default lane count
//   DEF_SAMPLE_W       default bits per sample
//   DEF_TIMEOUT_CYCLES default partial-frame timeout (one 24 kHz period at 98.3 MHz)
//   STATS_W            width of the frame/drop statistics counters
//   sat_add            saturating add for the statistics counters
package mic_sched_pkg;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_COLLECT = 2'd1,
    ST_EMIT    = 2'd2
  } state_e;

  localparam int DEF_NUM_MICS       = 3;
  localparam int DEF_SAMPLE_W       = 16;
  localparam int DEF_TIMEOUT_CYCLES = 4096;
  localparam int STATS_W            = 16;

  function automatic logic [STATS_W-1:0] sat_add(input logic [STATS_W-1:0] a,
                                                 input logic [STATS_W-1:0] b);
    logic [STATS_W:0] sum;
    sum = {1'b0, a} + {1'b0, b};
    return sum[STATS_W] ? '1 : sum[STATS_W-1:0];
  endfunction

endpackage

// File: rtl/mic_frame_scheduler_if.sv
// rtl/mic_frame_scheduler_if.sv - sample-in / frame-out bundle for mic_frame_scheduler
//
// Signals:
//   valid_in        per-lane one-cycle sample strobe
//   sample_in       lane-packed samples, lane i at [i*SAMPLE_W +: SAMPLE_W]
//   frame_ready_in  downstream accepts the frame
//   frame_valid_out frame available
//   frame_out       lane-packed frame (same layout as sample_in)
//   present_out     per-lane fresh-sample flags (0 = zero-filled lane)
//   overrun_out     sticky dropped-sample flag
//   frames_out      accepted-frame count
//   drops_out       dropped-sample count
// Modports: slave = scheduler side, master = producer/consumer side.
interface mic_frame_scheduler_if import mic_sched_pkg::*; #(
  parameter int NUM_MICS = DEF_NUM_MICS,
  parameter int SAMPLE_W = DEF_SAMPLE_W
);
  logic [NUM_MICS-1:0]          valid_in;
  logic [NUM_MICS*SAMPLE_W-1:0] sample_in;
  logic                         frame_ready_in;
  logic                         frame_valid_out;
  logic [NUM_MICS*SAMPLE_W-1:0] frame_out;
  logic [NUM_MICS-1:0]          present_out;
  logic                         overrun_out;
  logic [STATS_W-1:0]           frames_out;
  logic [STATS_W-1:0]           drops_out;

  modport slave (
    input  valid_in, sample_in, frame_ready_in,
    output frame_valid_out, frame_out, present_out, overrun_out, frames_out, drops_out
  );

  modport master (
    output valid_in, sample_in, frame_ready_in,
    input  frame_valid_out, frame_out, present_out, overrun_out, frames_out, drops_out
  );
endinterface

// File: rtl/mic_lane_slot.sv
// rtl/mic_lane_slot.sv - one mic lane: capture register + present bit, one-deep pending slot
//
// Ports:
//   clk_in, rst_in     clock, asynchronous active-high reset
//   valid_in           sample strobe for this lane
//   sample_in          sample value
//   hold_in            frame is being offered downstream; new samples may only queue
//   load_in            frame handshake: pending moves into capture
//   present_out        lane holds a fresh sample
//   present_next_out   present bit after this cycle (lets the FSM react in the same cycle)
//   data_out           captured sample, zero when not present
//   drop_out           one-cycle pulse when a sample is lost
module mic_lane_slot import mic_sched_pkg::*; #(
  parameter int SAMPLE_W = DEF_SAMPLE_W
) (
  input  logic                clk_in,
  input  logic                rst_in,
  input  logic                valid_in,
  input  logic [SAMPLE_W-1:0] sample_in,
  input  logic                hold_in,
  input  logic                load_in,
  output logic                present_out,
  output logic                present_next_out,
  output logic [SAMPLE_W-1:0] data_out,
  output logic                drop_out
);

  logic                present_q, present_d;
  logic                pending_q, pending_d;
  logic [SAMPLE_W-1:0] capture_q, capture_d;
  logic [SAMPLE_W-1:0] pend_data_q, pend_data_d;

  always_comb begin
    present_d   = present_q;
    pending_d   = pending_q;
    capture_d   = capture_q;
    pend_data_d = pend_data_q;
    drop_out    = 1'b0;
    if (load_in) begin
      // Queued sample opens the next frame; a sample arriving now takes the
      // freed pending slot, or the lane itself if nothing was queued.
      if (pending_q) begin
        capture_d = pend_data_q;
        present_d = 1'b1;
        pending_d = valid_in;
        if (valid_in) pend_data_d = sample_in;
      end else begin
        present_d = valid_in;
        pending_d = 1'b0;
        if (valid_in) capture_d = sample_in;
      end
    end else if (valid_in) begin
      if (!hold_in && !present_q) begin
        capture_d = sample_in;
        present_d = 1'b1;
      end else if (!pending_q) begin
        pending_d   = 1'b1;
        pend_data_d = sample_in;
      end else begin
        drop_out = 1'b1;
      end
    end
  end

  always_ff @(posedge clk_in or posedge rst_in) begin
    if (rst_in) begin
      present_q   <= 1'b0;
      pending_q   <= 1'b0;
      capture_q   <= '0;
      pend_data_q <= '0;
    end else begin
      present_q   <= present_d;
      pending_q   <= pending_d;
      capture_q   <= capture_d;
      pend_data_q <= pend_data_d;
    end
  end

  assign present_out      = present_q;
  assign present_next_out = present_d;
  // Missing lanes of a timed-out frame read as zero without clearing storage.
  assign data_out         = present_q ? capture_q : '0;

endmodule

// File: rtl/mic_frame_scheduler.sv
// rtl/mic_frame_scheduler.sv - aligns per-mic I2S sample strobes into one valid/ready frame stream
//
// Ports:
//   clk_in  audio clock, rising edge
//   rst_in  asynchronous active-high reset
//   bus     mic_frame_scheduler_if.slave (samples in, frames/flags/stats out)
// Optional feature: define MIC_SCHED_STATS_EN to build the frames_out/drops_out
// counters; otherwise both read as zero.
module mic_frame_scheduler import mic_sched_pkg::*; #(
  parameter int NUM_MICS       = DEF_NUM_MICS,
  parameter int SAMPLE_W       = DEF_SAMPLE_W,
  parameter int TIMEOUT_CYCLES = DEF_TIMEOUT_CYCLES
) (
  input  logic                  clk_in,
  input  logic                  rst_in,
  mic_frame_scheduler_if.slave  bus
);

  localparam int TIMER_W = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
  localparam logic [TIMER_W-1:0] TIMER_LAST = TIMER_W'(TIMEOUT_CYCLES - 1);

  state_e                       state_q, state_d;
  logic [TIMER_W-1:0]           timer_q, timer_d, timer_inc;
  logic                         overrun_q, overrun_d;
  logic [NUM_MICS-1:0]          present, present_next, drop;
  logic [NUM_MICS*SAMPLE_W-1:0] frame_data;
  logic                         hold, load;

  assign hold = (state_q == ST_EMIT);
  assign load = hold & bus.frame_ready_in;

  for (genvar i = 0; i < NUM_MICS; i++) begin : g_lane
    mic_lane_slot #(.SAMPLE_W(SAMPLE_W)) u_lane (
      .clk_in           (clk_in),
      .rst_in           (rst_in),
      .valid_in         (bus.valid_in[i]),
      .sample_in        (bus.sample_in[i*SAMPLE_W +: SAMPLE_W]),
      .hold_in          (hold),
      .load_in          (load),
      .present_out      (present[i]),
      .present_next_out (present_next[i]),
      .data_out         (frame_data[i*SAMPLE_W +: SAMPLE_W]),
      .drop_out         (drop[i])
    );
  end

  // Decisions use present_next so a completing capture raises valid on the
  // very next cycle, and a capture on the timeout cycle still counts.
  always_comb begin
    state_d   = state_q;
    timer_d   = timer_q;
    timer_inc = timer_q + 1'b1;
    overrun_d = overrun_q | (|drop);
    unique case (state_q)
      ST_IDLE: begin
        if (|present_next) begin
          timer_d = '0;
          state_d = (&present_next) ? ST_EMIT : ST_COLLECT;
        end
      end
      ST_COLLECT: begin
        timer_d = timer_inc;
        if ((&present_next) || (timer_inc == TIMER_LAST)) state_d = ST_EMIT;
      end
      ST_EMIT: begin
        if (load) begin
          timer_d = '0;
          if (&present_next)      state_d = ST_EMIT;
          else if (|present_next) state_d = ST_COLLECT;
          else                    state_d = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk_in or posedge rst_in) begin
    if (rst_in) begin
      state_q   <= ST_IDLE;
      timer_q   <= '0;
      overrun_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      timer_q   <= timer_d;
      overrun_q <= overrun_d;
    end
  end

  assign bus.frame_valid_out = hold;
  assign bus.frame_out       = frame_data;
  assign bus.present_out     = present;
  assign bus.overrun_out     = overrun_q;

`ifdef MIC_SCHED_STATS_EN
  logic [STATS_W-1:0] frames_q, frames_d;
  logic [STATS_W-1:0] drops_q, drops_d;
  logic [STATS_W-1:0] drop_cnt;

  always_comb begin
    drop_cnt = '0;
    for (int i = 0; i < NUM_MICS; i++) drop_cnt = drop_cnt + STATS_W'(drop[i]);
    frames_d = load ? sat_add(frames_q, STATS_W'(1)) : frames_q;
    drops_d  = sat_add(drops_q, drop_cnt);
  end

  always_ff @(posedge clk_in or posedge rst_in) begin
    if (rst_in) begin
      frames_q <= '0;
      drops_q  <= '0;
    end else begin
      frames_q <= frames_d;
      drops_q  <= drops_d;
    end
  end

  assign bus.frames_out = frames_q;
  assign bus.drops_out  = drops_q;
`else
  assign bus.frames_out = '0;
  assign bus.drops_out  = '0;
`endif

endmodule

// File: tb/tb_mic_frame_scheduler.sv
// tb/tb_mic_frame_scheduler.sv - self-checking bench for mic_frame_scheduler
module tb_mic_frame_scheduler;
  localparam int N = 3;
  localparam int W = 16;
  localparam int T = 4096;

  logic clk_in = 1'b0;
  logic rst_in = 1'b1;
  always #5 clk_in = ~clk_in;

  mic_frame_scheduler_if #(.NUM_MICS(N), .SAMPLE_W(W)) bus ();

  mic_frame_scheduler #(.NUM_MICS(N), .SAMPLE_W(W), .TIMEOUT_CYCLES(T)) dut (
    .clk_in (clk_in),
    .rst_in (rst_in),
    .bus    (bus.slave)
  );

  int checks = 0;
  int errors = 0;
  int cyc    = 0;
  always @(posedge clk_in) cyc <= cyc + 1;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Behavioural model: a frame is "open" once any lane holds a sample, and
  // "offered" once complete or aged out; each lane may queue one extra sample.
  bit             m_offer;
  int             m_age;
  bit             m_cp [N];
  logic [W-1:0]   m_cd [N];
  bit             m_pp [N];
  logic [W-1:0]   m_pd [N];
  bit             m_ovr;
  int             m_frames, m_drops;

  function automatic int count_present();
    int c = 0;
    for (int i = 0; i < N; i++) c += m_cp[i];
    return c;
  endfunction

  function automatic void model_reset();
    m_offer = 0; m_age = 0; m_ovr = 0; m_frames = 0; m_drops = 0;
    for (int i = 0; i < N; i++) begin
      m_cp[i] = 0; m_pp[i] = 0; m_cd[i] = '0; m_pd[i] = '0;
    end
  endfunction

  function automatic void model_drop();
    m_ovr = 1;
    if (m_drops < 65535) m_drops++;
  endfunction

  function automatic void model_step(input logic [N-1:0] v, input logic [N*W-1:0] smp,
                                     input logic rdy);
    logic [W-1:0] s;
    int was_open;
    if (m_offer && rdy) begin
      if (m_frames < 65535) m_frames++;
      for (int i = 0; i < N; i++) begin
        s = smp[i*W +: W];
        if (m_pp[i]) begin
          m_cd[i] = m_pd[i]; m_cp[i] = 1; m_pp[i] = v[i];
          if (v[i]) m_pd[i] = s;
        end else begin
          m_cp[i] = v[i];
          if (v[i]) m_cd[i] = s;
        end
      end
      m_age   = 0;
      m_offer = (count_present() == N);
    end else if (m_offer) begin
      for (int i = 0; i < N; i++)
        if (v[i]) begin
          if (!m_pp[i]) begin m_pp[i] = 1; m_pd[i] = smp[i*W +: W]; end
          else model_drop();
        end
    end else begin
      was_open = count_present();
      for (int i = 0; i < N; i++)
        if (v[i]) begin
          if (!m_cp[i])      begin m_cp[i] = 1; m_cd[i] = smp[i*W +: W]; end
          else if (!m_pp[i]) begin m_pp[i] = 1; m_pd[i] = smp[i*W +: W]; end
          else model_drop();
        end
      if (was_open != 0) begin
        m_age++;
        if (count_present() == N || m_age == T - 1) m_offer = 1;
      end else if (count_present() != 0) begin
        m_age   = 0;
        m_offer = (count_present() == N);
      end
    end
  endfunction

  always @(posedge clk_in or posedge rst_in) begin
    if (rst_in) model_reset();
    else        model_step(bus.valid_in, bus.sample_in, bus.frame_ready_in);
  end

  // Continuous comparison against the model, away from the active edge.
  always @(negedge clk_in) begin
    logic [N*W-1:0] ef;
    logic [N-1:0]   ep;
    int             efr, edr;
    if (!rst_in) begin
      for (int i = 0; i < N; i++) begin
        ep[i]          = m_cp[i];
        ef[i*W +: W]   = m_cp[i] ? m_cd[i] : '0;
      end
`ifdef MIC_SCHED_STATS_EN
      efr = m_frames; edr = m_drops;
`else
      efr = 0; edr = 0;
`endif
      check("model_valid",   bus.frame_valid_out, m_offer);
      check("model_frame",   bus.frame_out, ef);
      check("model_present", bus.present_out, ep);
      check("model_overrun", bus.overrun_out, m_ovr);
      check("model_frames",  bus.frames_out, efr[15:0]);
      check("model_drops",   bus.drops_out, edr[15:0]);
    end
  end

  task automatic drive(input logic [N-1:0] v, input logic [N*W-1:0] s, input logic r);
    @(posedge clk_in);
    #1;
    bus.valid_in       = v;
    bus.sample_in      = s;
    bus.frame_ready_in = r;
  endtask

  int c0;
  bit stable;
  logic [N-1:0] rv;
  logic [N*W-1:0] rs;

  initial begin
    bus.valid_in       = '0;
    bus.sample_in      = '0;
    bus.frame_ready_in = 1'b0;
    repeat (3) @(posedge clk_in);
    #1;
    check("rst_valid",   bus.frame_valid_out, 0);
    check("rst_frame",   bus.frame_out, 0);
    check("rst_present", bus.present_out, 0);
    check("rst_overrun", bus.overrun_out, 0);
    check("rst_frames",  bus.frames_out, 0);
    check("rst_drops",   bus.drops_out, 0);
    rst_in = 1'b0;

    // Staggered strobes, ready high: valid the cycle after the last capture, one cycle long.
    drive(3'b001, {16'h0000, 16'h0000, 16'h1111}, 1'b1);
    drive(3'b000, '0, 1'b1);
    drive(3'b010, {16'h0000, 16'h2222, 16'h0000}, 1'b1);
    drive(3'b000, '0, 1'b1);
    drive(3'b000, '0, 1'b1);
    drive(3'b100, {16'h3333, 16'h0000, 16'h0000}, 1'b1);
    check("t1_not_yet", bus.frame_valid_out, 0);
    drive(3'b000, '0, 1'b1);
    check("t1_valid",   bus.frame_valid_out, 1);
    check("t1_frame",   bus.frame_out, 48'h3333_2222_1111);
    check("t1_present", bus.present_out, 3'b111);
    drive(3'b000, '0, 1'b1);
    check("t1_one_cycle", bus.frame_valid_out, 0);

    // Partial frame forced out by timeout.
    drive(3'b001, {16'h0000, 16'h0000, 16'h5555}, 1'b1);
    c0 = cyc;
    drive(3'b100, {16'h7777, 16'h0000, 16'h0000}, 1'b1);
    do drive(3'b000, '0, 1'b1);
    while (!bus.frame_valid_out && cyc < c0 + 5000);
    check("t2_timeout_latency", cyc - c0, T);
    check("t2_present", bus.present_out, 3'b101);
    check("t2_frame",   bus.frame_out, 48'h7777_0000_5555);
    drive(3'b000, '0, 1'b1);
    check("t2_taken", bus.frame_valid_out, 0);

    // Back-pressure for 20 cycles; lane 1 queues one sample for the next frame.
    drive(3'b111, {16'hC3C3, 16'hB2B2, 16'hA1A1}, 1'b0);
    drive(3'b010, {16'h0000, 16'hAAAA, 16'h0000}, 1'b0);
    check("t3_valid", bus.frame_valid_out, 1);
    check("t3_frame", bus.frame_out, 48'hC3C3_B2B2_A1A1);
    stable = 1;
    repeat (19) begin
      drive(3'b000, '0, 1'b0);
      if (bus.frame_out !== 48'hC3C3_B2B2_A1A1 || bus.frame_valid_out !== 1'b1) stable = 0;
    end
    check("t3_held", stable, 1);
    drive(3'b000, '0, 1'b1);
    drive(3'b000, '0, 1'b0);
    check("t3_next_valid",   bus.frame_valid_out, 0);
    check("t3_next_present", bus.present_out, 3'b010);
    check("t3_next_frame",   bus.frame_out, 48'h0000_AAAA_0000);
    drive(3'b101, {16'h1234, 16'h0000, 16'h5678}, 1'b0);
    drive(3'b000, '0, 1'b1);
    check("t3_second_frame", bus.frame_out, 48'h1234_AAAA_5678);
    drive(3'b000, '0, 1'b0);

    // Two strobes on one lane while offered: second is dropped.
    drive(3'b111, {16'h0003, 16'h0002, 16'h0001}, 1'b0);
    drive(3'b001, {16'h0000, 16'h0000, 16'h0F0F}, 1'b0);
    drive(3'b001, {16'h0000, 16'h0000, 16'hF0F0}, 1'b0);
    drive(3'b000, '0, 1'b0);
    check("t4_overrun", bus.overrun_out, 1);
`ifdef MIC_SCHED_STATS_EN
    check("t4_drops",  bus.drops_out, 1);
    check("t4_frames", bus.frames_out, 4);
`else
    check("t4_drops",  bus.drops_out, 0);
    check("t4_frames", bus.frames_out, 0);
`endif
    drive(3'b000, '0, 1'b1);
    drive(3'b000, '0, 1'b0);
    check("t4_pending_present", bus.present_out, 3'b001);
    check("t4_pending_frame",   bus.frame_out, 48'h0000_0000_0F0F);
    drive(3'b110, {16'h00CC, 16'h00BB, 16'h0000}, 1'b0);
    drive(3'b000, '0, 1'b1);
    drive(3'b000, '0, 1'b0);

    // Last capture lands exactly on the timeout cycle: frame is full.
    drive(3'b001, {16'h0000, 16'h0000, 16'h1111}, 1'b0);
    c0 = cyc;
    while (cyc < c0 + T - 2) drive(3'b000, '0, 1'b0);
    check("t5_before_timeout", bus.frame_valid_out, 0);
    drive(3'b110, {16'h3333, 16'h2222, 16'h0000}, 1'b0);
    drive(3'b000, '0, 1'b0);
    check("t5_valid",   bus.frame_valid_out, 1);
    check("t5_present", bus.present_out, 3'b111);
    drive(3'b000, '0, 1'b1);
    drive(3'b000, '0, 1'b0);

    // Random traffic against the model.
    repeat (3000) begin
      for (int i = 0; i < N; i++) rv[i] = ($urandom_range(0, 5) == 0);
      rs = {$urandom(), $urandom()};
      drive(rv, rs, ($urandom_range(0, 3) != 0));
    end
    repeat (8) drive(3'b000, '0, 1'b1);

    // Asynchronous reset while a frame is offered and not accepted.
    drive(3'b111, {16'h0C0C, 16'h0B0B, 16'h0A0A}, 1'b0);
    drive(3'b010, {16'h0000, 16'h9999, 16'h0000}, 1'b0);
    check("t6_pre_valid", bus.frame_valid_out, 1);
    #2 rst_in = 1'b1;
    #1;
    check("t6_async_valid",   bus.frame_valid_out, 0);
    check("t6_async_present", bus.present_out, 0);
    check("t6_async_overrun", bus.overrun_out, 0);
    @(posedge clk_in);
    #1;
    rst_in = 1'b0;
    bus.valid_in = '0;
    bus.frame_ready_in = 1'b1;
    drive(3'b111, {16'hDEAD, 16'hBEEF, 16'hCAFE}, 1'b1);
    drive(3'b000, '0, 1'b1);
    check("t6_fresh_valid", bus.frame_valid_out, 1);
    check("t6_fresh_frame", bus.frame_out, 48'hDEAD_BEEF_CAFE);
    drive(3'b000, '0, 1'b1);
    check("t6_fresh_taken", bus.frame_valid_out, 0);
    drive(3'b000, '0, 1'b1);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
